// File: rtl/finalproject_pkg.sv
// Shared definitions for the keycode receive path: register map addresses,
// STATUS/CTRL/CLEAR bit positions and keycode width.
package finalproject_pkg;

  localparam int KEYCODE_W = 8;
  localparam int DROP_W    = 8;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int STAT_EMPTY_BIT = 4;
  localparam int STAT_FULL_BIT  = 5;
  localparam int STAT_OVF_BIT   = 6;
  localparam int STAT_DROP_LSB  = 8;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_OVF_EN_BIT = 1;

  localparam int CLR_OVF_BIT  = 0;
  localparam int CLR_DROP_BIT = 1;

endpackage

// File: rtl/finalproject_sync_fifo.sv
// Single-clock first-word fall-through FIFO. The caller guarantees push only
// when not full (or popping) and pop only when not empty.
module finalproject_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   cnt,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_r;

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_r  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_r <= cnt_r + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign cnt   = cnt_r;
  assign full  = (cnt_r == FULL_CNT);
  assign empty = (cnt_r == '0);

endmodule

// File: rtl/finalproject_keycode_rx_fifo.sv
// Avalon-MM slave that buffers hardware keycodes for the Nios II CPU.
// Holds register decode, overflow/drop tracking and the interrupt register.
module finalproject_keycode_rx_fifo
  import finalproject_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA_W     = KEYCODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              irq
);

  logic [DATA_W-1:0]   head;
  logic [DEPTH_LOG2:0] cnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                drop;
  logic                rd_hit;
  logic                wr_hit;
  logic                clr_ovf;
  logic                clr_drop;
  logic                ctrl_wr;
  logic                ovf;
  logic [DROP_W-1:0]   drop_cnt;
  logic                irq_en;
  logic                ovf_en;
  logic                irq_p1;
  logic                unused_wdata;

  // Drop counter stops at all-ones rather than wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign rd_hit   = chipselect & ~read_n;
  assign wr_hit   = chipselect & ~write_n;
  assign pop      = rd_hit & (address == ADDR_DATA) & ~empty;
  assign push     = in_valid & (~full | pop);
  assign drop     = in_valid & full & ~pop;
  assign clr_ovf  = wr_hit & (address == ADDR_CLEAR) & writedata[CLR_OVF_BIT];
  assign clr_drop = wr_hit & (address == ADDR_CLEAR) & writedata[CLR_DROP_BIT];
  assign ctrl_wr  = wr_hit & (address == ADDR_CTRL);
  assign unused_wdata = ^writedata[31:2];

  finalproject_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  // Overflow/drop tracking, control bits and interrupt; a new drop beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
      irq_en   <= 1'b0;
      ovf_en   <= 1'b0;
      irq_p1   <= 1'b0;
    end else begin
      ovf <= drop | (ovf & ~clr_ovf);
      if (clr_drop)  drop_cnt <= {{(DROP_W-1){1'b0}}, drop};
      else if (drop) drop_cnt <= sat_inc(drop_cnt);
      if (ctrl_wr) begin
        irq_en <= writedata[CTRL_IRQ_EN_BIT];
        ovf_en <= writedata[CTRL_OVF_EN_BIT];
      end
      irq_p1 <= (irq_en & ~empty) | (ovf_en & ovf);
    end
  end

  // Zero-latency read mux; an empty DATA read returns 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) readdata[DATA_W-1:0] = head;
      end
      ADDR_STATUS: begin
        readdata[DEPTH_LOG2:0]                      = cnt;
        readdata[STAT_EMPTY_BIT]                    = empty;
        readdata[STAT_FULL_BIT]                     = full;
        readdata[STAT_OVF_BIT]                      = ovf;
        readdata[STAT_DROP_LSB +: DROP_W]           = drop_cnt;
      end
      ADDR_CTRL: begin
        readdata[CTRL_IRQ_EN_BIT] = irq_en;
        readdata[CTRL_OVF_EN_BIT] = ovf_en;
      end
      default: readdata = '0;
    endcase
  end

  assign in_ready = ~full;
  assign irq      = irq_p1;

endmodule

// File: tb/tb_finalproject_keycode_rx_fifo.sv
// Directed bench for the keycode receive FIFO slave.
module tb_finalproject_keycode_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  finalproject_keycode_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge; each occupies one clock cycle.
  task automatic push(input logic [7:0] c);
    in_valid = 1'b1;
    in_data  = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = wd;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  e;

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0; in_data = '0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1. reset state
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    bus_read(2'd1, d); check("reset_status", d, 32'h10);
    bus_read(2'd0, d); check("empty_pop_data", d, 32'h0);
    bus_read(2'd1, d); check("empty_pop_status", d, 32'h10);
    bus_read(2'd2, d); check("reset_ctrl", d, 32'h0);

    // 2. three keycodes in order
    push(8'h1A); push(8'h04); push(8'h16);
    bus_read(2'd1, d); check("status_cnt3", d, 32'h03);
    bus_read(2'd0, d); check("rd_1A", d, 32'h1A);
    bus_read(2'd0, d); check("rd_04", d, 32'h04);
    bus_read(2'd0, d); check("rd_16", d, 32'h16);
    bus_read(2'd1, d); check("status_drained", d, 32'h10);

    // 3. overfill by one
    for (int i = 1; i <= 9; i++) push(8'(i));
    bus_read(2'd1, d); check("status_ovf", d, 32'h168);
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0, d); check("rd_overfill", d, 32'(i));
    end
    bus_read(2'd1, d); check("status_sticky", d, 32'h150);
    bus_write(2'd3, 32'h3);
    bus_read(2'd1, d); check("status_cleared", d, 32'h10);

    // 4. push and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) push(8'(i));
    in_valid = 1'b1; in_data = 8'h2C;
    chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
    #1 d = readdata;
    @(negedge clk);
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    check("full_pushpop_head", d, 32'h01);
    bus_read(2'd1, d); check("full_pushpop_status", d, 32'h28);
    for (int i = 2; i <= 8; i++) begin
      bus_read(2'd0, d); check("rd_after_pushpop", d, 32'(i));
    end
    bus_read(2'd0, d); check("rd_2C", d, 32'h2C);
    bus_read(2'd1, d); check("status_after_2C", d, 32'h10);

    // 5. interrupts
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d); check("ctrl_rb", d, 32'h1);
    push(8'h07);
    check("irq_1cyc", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_2cyc", {31'b0, irq}, 32'h1);
    bus_read(2'd0, d); check("rd_07", d, 32'h07);
    @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h2);
    for (int i = 0; i < 9; i++) push(8'(8'h60 + i));
    repeat (2) @(negedge clk);
    check("irq_ovf", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d); check("rd_ovf_drain", d, 32'(8'h60 + i));
    end
    repeat (2) @(negedge clk);
    check("irq_ovf_hold", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_ovf_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd1, d); check("status_drop_kept", d, 32'h110);
    bus_write(2'd3, 32'h2);
    bus_read(2'd1, d); check("status_drop_clr", d, 32'h10);
    bus_write(2'd2, 32'h0);

    // W1C racing a new drop, then drop counter saturation
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    bus_read(2'd1, d); check("status_drop2", d, 32'h268);
    in_valid = 1'b1; in_data = 8'h99;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h3;
    @(negedge clk);
    in_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd1, d); check("clr_vs_drop", d, 32'h168);
    for (int i = 0; i < 300; i++) push(8'hEE);
    bus_read(2'd1, d); check("drop_saturate", d, 32'hFF68);
    bus_write(2'd3, 32'h3);
    bus_read(2'd1, d); check("status_full_clr", d, 32'h28);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d); check("rd_sat_drain", d, 32'(8'h80 + i));
    end
    bus_read(2'd1, d); check("status_sat_empty", d, 32'h10);

    // 6. pointer wrap with interleaved push/pop
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h40 + i));
      q.push_back(8'(8'h40 + i));
      if ((i % 3) != 0) begin
        e = q.pop_front();
        bus_read(2'd0, d); check("rd_wrap", d, {24'b0, e});
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      bus_read(2'd0, d); check("rd_wrap_drain", d, {24'b0, e});
    end
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    bus_read(2'd1, d); check("status_cnt5", d, 32'h05);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    bus_read(2'd1, d); check("status_after_reset", d, 32'h10);
    bus_read(2'd0, d); check("data_after_reset", d, 32'h0);
    check("in_ready_after_reset", {31'b0, in_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
